// File: rtl/spi_reg_receiver_if.sv
// Bus bundle between the SPI input synchronizers, the register receiver and
// the PWM peripheral.
//   sclk, copi, ncs   synchronized SPI inputs (mode 0, ncs active-low)
//   reg_0..reg_4      control registers (out_7_0, out_15_8, pwm_7_0,
//                     pwm_15_8, duty)
//   frame_done        1-cycle pulse: a frame closed with exactly 16 bits
//   frame_err         1-cycle pulse: a frame closed with any other bit count
//   fsm_state         receiver state, for observation only
// Modports: master drives the SPI pins and observes the outputs; slave is the
// receiver side.
interface spi_reg_receiver_if #(
  parameter int DATA_W = 8
);
  logic              sclk;
  logic              copi;
  logic              ncs;
  logic [DATA_W-1:0] reg_0;
  logic [DATA_W-1:0] reg_1;
  logic [DATA_W-1:0] reg_2;
  logic [DATA_W-1:0] reg_3;
  logic [DATA_W-1:0] reg_4;
  logic              frame_done;
  logic              frame_err;
  logic [1:0]        fsm_state;

  modport master (
    output sclk, copi, ncs,
    input  reg_0, reg_1, reg_2, reg_3, reg_4, frame_done, frame_err, fsm_state
  );

  modport slave (
    input  sclk, copi, ncs,
    output reg_0, reg_1, reg_2, reg_3, reg_4, frame_done, frame_err, fsm_state
  );
endinterface

// File: rtl/spi_reg_receiver.sv
// SPI mode-0 write-only register receiver.
// Samples the already-synchronized sclk/copi/ncs on clk, assembles 16-bit
// frames {rw, addr[6:0], data[7:0]} MSB first, and writes data into one of
// five 8-bit control registers when rw=1 and addr < NUM_REGS.
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous reset, active-high
//   bus   spi_reg_receiver_if.slave (SPI inputs, registers, pulses, state)
// Handshake: there is no backpressure. frame_done / frame_err are single-cycle
// strobes, mutually exclusive, asserted on the same clk edge that any register
// write becomes visible; a consumer samples them every cycle.
module spi_reg_receiver #(
  parameter int NUM_REGS = 5,
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  spi_reg_receiver_if.slave    bus
);
  localparam int FRAME_W = 1 + ADDR_W + DATA_W;

  typedef enum logic [1:0] {
    WAIT_HI = 2'd0,
    IDLE    = 2'd1,
    SHIFT   = 2'd2
  } state_t;

  state_t              state;
  logic [FRAME_W-1:0]  shift;
  logic [4:0]          bit_cnt;
  logic                sclk_q;
  logic                ncs_q;
  logic                frame_done;
  logic                frame_err;
  logic [DATA_W-1:0]   regs [NUM_REGS];

  logic sclk_rise;
  logic ncs_fall;
  logic ncs_rise;

  assign sclk_rise = bus.sclk & ~sclk_q;
  assign ncs_fall  = ~bus.ncs & ncs_q;
  assign ncs_rise  = bus.ncs & ~ncs_q;

  logic              frame_rw;
  logic [ADDR_W-1:0] frame_addr;
  logic [DATA_W-1:0] frame_data;

  assign frame_rw   = shift[FRAME_W-1];
  assign frame_addr = shift[FRAME_W-2 -: ADDR_W];
  assign frame_data = shift[DATA_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= WAIT_HI;
      shift      <= '0;
      bit_cnt    <= '0;
      sclk_q     <= 1'b0;
      ncs_q      <= 1'b1;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      sclk_q     <= bus.sclk;
      ncs_q      <= bus.ncs;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        // Never join a frame already in progress: wait for ncs to go high.
        WAIT_HI: if (bus.ncs) state <= IDLE;
        IDLE: begin
          if (ncs_fall) begin
            shift   <= '0;
            bit_cnt <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          // ncs_rise takes priority: an sclk edge in the same cycle is dropped
          // and the count from before that edge is evaluated.
          if (ncs_rise) begin
            state <= IDLE;
            if (bit_cnt == 5'(FRAME_W)) begin
              frame_done <= 1'b1;
              if (frame_rw) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                  if (frame_addr == ADDR_W'(i)) regs[i] <= frame_data;
                end
              end
            end else begin
              frame_err <= 1'b1;
            end
          end else if (sclk_rise && !bus.ncs) begin
            shift <= {shift[FRAME_W-2:0], bus.copi};
            // Saturate one past a full frame so overlong frames stay invalid.
            if (bit_cnt != 5'(FRAME_W + 1)) bit_cnt <= bit_cnt + 5'd1;
          end
        end
        default: state <= WAIT_HI;
      endcase
    end
  end

  assign bus.reg_0      = regs[0];
  assign bus.reg_1      = regs[1];
  assign bus.reg_2      = regs[2];
  assign bus.reg_3      = regs[3];
  assign bus.reg_4      = regs[4];
  assign bus.frame_done = frame_done;
  assign bus.frame_err  = frame_err;
  assign bus.fsm_state  = state;
endmodule
